// File: rtl/svif_chan_pipe_if.sv
// Signal bundle between the pad-level interface and svif_chan_pipe.
// The master drives lanes, passthrough and config; the slave returns the processed results.
interface svif_chan_pipe_if #(
    parameter int CHANNELS = 2,
    parameter int SIG_W    = 2,
    parameter int PASS_W   = 16,
    parameter int ACC_W    = 22,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic [CHANNELS*SIG_W-1:0] sig;
    logic                      flip;
    logic [PASS_W-1:0]         pass_in;
    logic                      cfg_we;
    logic [CH_W-1:0]           cfg_ch;
    logic [2:0]                cfg_mode;
    logic [CHANNELS*SIG_W-1:0] sig_out;
    logic [PASS_W-1:0]         pass_out;
    logic [CHANNELS*ACC_W-1:0] acc_out;
    logic [CHANNELS-1:0]       acc_sat;
    logic                      out_valid;

    modport master (
        output sig, flip, pass_in, cfg_we, cfg_ch, cfg_mode,
        input  sig_out, pass_out, acc_out, acc_sat, out_valid
    );

    modport slave (
        input  sig, flip, pass_in, cfg_we, cfg_ch, cfg_mode,
        output sig_out, pass_out, acc_out, acc_sat, out_valid
    );
endinterface

// File: rtl/svif_chan_pipe.sv
// Multi-lane chip-top datapath: per-lane mode/flip, DEPTH-stage delay line and accumulator.
// Define SVIF_ACC_WRAP_EN for wrapping accumulators with a one-cycle wrap pulse on acc_sat.
module svif_chan_pipe #(
    parameter int CHANNELS = 2,
    parameter int SIG_W    = 2,
    parameter int PASS_W   = 16,
    parameter int DEPTH    = 2,
    parameter int ACC_W    = 22
) (
    input logic             clk,
    input logic             rst,
    svif_chan_pipe_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ACC_W:0] SUM_MAX = {1'b0, {ACC_W{1'b1}}};

    typedef enum logic [2:0] {
        MODE_PASS  = 3'd0,
        MODE_HOLD  = 3'd1,
        MODE_ZERO  = 3'd2,
        MODE_COUNT = 3'd3
    } mode_e;

    logic [DEPTH-1:0][CHANNELS*SIG_W-1:0] stage_q, stage_d;
    logic [DEPTH-1:0][PASS_W-1:0]         pass_q, pass_d;
    logic [CHANNELS-1:0][ACC_W-1:0]       acc_q, acc_d;
    logic [CHANNELS-1:0]                  sat_q, sat_d;
    logic [CHANNELS-1:0][2:0]             mode_q, mode_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;

    logic [CHANNELS-1:0][SIG_W-1:0]       eff;
    logic [CHANNELS-1:0][ACC_W:0]         sum;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        assign eff[g] = bus.flip ? ~bus.sig[g*SIG_W +: SIG_W] : bus.sig[g*SIG_W +: SIG_W];
        assign sum[g] = {1'b0, acc_q[g]} + (ACC_W+1)'(eff[g]);
    end

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block can infer a latch.
        stage_d = stage_q;
        pass_d  = pass_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;

        if (cnt_q != CNT_W'(DEPTH)) begin
            cnt_d = cnt_q + 1'b1;
        end

        for (int d = 1; d < DEPTH; d++) begin
            stage_d[d] = stage_q[d-1];
            pass_d[d]  = pass_q[d-1];
        end
        pass_d[0] = bus.pass_in;

        for (int c = 0; c < CHANNELS; c++) begin
`ifdef SVIF_ACC_WRAP_EN
            sat_d[c] = 1'b0;
`endif
            // Stage 0 of a HOLD lane keeps its previous value via the default above.
            case (mode_q[c])
                MODE_HOLD:  ;
                MODE_ZERO:  stage_d[0][c*SIG_W +: SIG_W] = '0;
                MODE_COUNT: stage_d[0][c*SIG_W +: SIG_W] = acc_q[c][SIG_W-1:0];
                default:    stage_d[0][c*SIG_W +: SIG_W] = eff[c];
            endcase

            if (mode_q[c] != MODE_HOLD) begin
`ifdef SVIF_ACC_WRAP_EN
                acc_d[c] = sum[c][ACC_W-1:0];
                sat_d[c] = sum[c][ACC_W];
`else
                if (sum[c] >= SUM_MAX) begin
                    acc_d[c] = SUM_MAX[ACC_W-1:0];
                    sat_d[c] = 1'b1;
                end else begin
                    acc_d[c] = sum[c][ACC_W-1:0];
                end
`endif
            end

            // Out-of-range cfg_ch never matches a lane, so such writes have no effect.
            if (bus.cfg_we && (int'(bus.cfg_ch) == c)) begin
                mode_d[c] = bus.cfg_mode;
                acc_d[c]  = '0;
                sat_d[c]  = 1'b0;
            end
        end
    end

    // NOTE: reset is synchronous and clears the delay lines too, so stale lane data never leaks out.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
            pass_q  <= '0;
            acc_q   <= '0;
            sat_q   <= '0;
            mode_q  <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            stage_q <= stage_d;
            pass_q  <= pass_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.sig_out   = stage_q[DEPTH-1];
    assign bus.pass_out  = pass_q[DEPTH-1];
    assign bus.acc_out   = acc_q;
    assign bus.acc_sat   = sat_q;
    assign bus.out_valid = (cnt_q == CNT_W'(DEPTH));
endmodule

// File: tb/tb_svif_chan_pipe.sv
// Directed bench for svif_chan_pipe (CHANNELS=2, SIG_W=2, DEPTH=2, ACC_W=4).
// Vector table for reset/latency/flip/saturation, hand sequences for the lane-0 mode changes.
module tb_svif_chan_pipe;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    svif_chan_pipe_if #(.CHANNELS(2), .SIG_W(2), .PASS_W(16), .ACC_W(4)) bus ();

    svif_chan_pipe #(
        .CHANNELS(2), .SIG_W(2), .PASS_W(16), .DEPTH(2), .ACC_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  sig;
        logic        flip;
        logic [15:0] pass_in;
        logic        cfg_we;
        logic        cfg_ch;
        logic [2:0]  cfg_mode;
        logic [3:0]  e_sig;
        logic [15:0] e_pass;
        logic [7:0]  e_acc;
        logic [1:0]  e_sat;
        logic        e_valid;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r, input logic [3:0] s, input logic f, input logic [15:0] p,
        input logic we, input logic ch, input logic [2:0] md,
        input logic [3:0] es, input logic [15:0] ep, input logic [7:0] ea,
        input logic [1:0] esat, input logic ev);
        vec_t v;
        v.rst = r; v.sig = s; v.flip = f; v.pass_in = p;
        v.cfg_we = we; v.cfg_ch = ch; v.cfg_mode = md;
        v.e_sig = es; v.e_pass = ep; v.e_acc = ea; v.e_sat = esat; v.e_valid = ev;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One lane-0 step with lane 1 idle (input 0, accumulator parked at 3).
    task automatic hstep(input int idx, input logic [1:0] l0, input logic we, input logic [2:0] md,
                         input logic [1:0] e_sig0, input logic [3:0] e_acc0);
        bus.sig      = {2'b00, l0};
        bus.flip     = 1'b0;
        bus.cfg_we   = we;
        bus.cfg_ch   = 1'b0;
        bus.cfg_mode = md;
        @(posedge clk);
        #1;
        check($sformatf("h%0d sig_out0", idx), 32'(bus.sig_out[1:0]), 32'(e_sig0));
        check($sformatf("h%0d acc_out", idx), 32'(bus.acc_out), 32'({4'h3, e_acc0}));
        check($sformatf("h%0d acc_sat", idx), 32'(bus.acc_sat), 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst          = 1'b1;
        bus.sig      = '0;
        bus.flip     = 1'b0;
        bus.pass_in  = '0;
        bus.cfg_we   = 1'b0;
        bus.cfg_ch   = 1'b0;
        bus.cfg_mode = '0;

        // rst sig flip pass we ch mode | sig_out pass_out acc_out acc_sat valid
        vecs.push_back(mk(1, 4'h0, 0, 16'h0000, 0, 0, 3'd0, 4'h0, 16'h0000, 8'h00, 2'b00, 0));
        vecs.push_back(mk(1, 4'h0, 0, 16'h0000, 0, 0, 3'd0, 4'h0, 16'h0000, 8'h00, 2'b00, 0));
        vecs.push_back(mk(0, 4'h0, 0, 16'h0000, 0, 0, 3'd0, 4'h0, 16'h0000, 8'h00, 2'b00, 0));
        vecs.push_back(mk(0, 4'h0, 0, 16'h0000, 0, 0, 3'd0, 4'h0, 16'h0000, 8'h00, 2'b00, 1));
        vecs.push_back(mk(0, 4'h9, 0, 16'hA5A5, 0, 0, 3'd0, 4'h0, 16'h0000, 8'h21, 2'b00, 1));
        vecs.push_back(mk(0, 4'h9, 1, 16'hA5A5, 0, 0, 3'd0, 4'h9, 16'hA5A5, 8'h33, 2'b00, 1));
        vecs.push_back(mk(0, 4'h0, 0, 16'h1234, 0, 0, 3'd0, 4'h6, 16'hA5A5, 8'h33, 2'b00, 1));
        vecs.push_back(mk(0, 4'h0, 0, 16'h0000, 0, 0, 3'd0, 4'h0, 16'h1234, 8'h33, 2'b00, 1));
        // rst together with a HOLD write to lane 0: reset wins, lane 0 stays PASS
        vecs.push_back(mk(1, 4'hF, 0, 16'hBEEF, 1, 0, 3'd1, 4'h0, 16'h0000, 8'h00, 2'b00, 0));
        vecs.push_back(mk(0, 4'hF, 0, 16'hBEEF, 0, 0, 3'd0, 4'h0, 16'h0000, 8'h33, 2'b00, 0));
        vecs.push_back(mk(0, 4'hF, 0, 16'h0000, 0, 0, 3'd0, 4'hF, 16'hBEEF, 8'h66, 2'b00, 1));
        vecs.push_back(mk(0, 4'hF, 0, 16'h0000, 0, 0, 3'd0, 4'hF, 16'h0000, 8'h99, 2'b00, 1));
        vecs.push_back(mk(0, 4'hF, 0, 16'h0000, 0, 0, 3'd0, 4'hF, 16'h0000, 8'hCC, 2'b00, 1));
`ifdef SVIF_ACC_WRAP_EN
        vecs.push_back(mk(0, 4'hF, 0, 16'h0000, 0, 0, 3'd0, 4'hF, 16'h0000, 8'hFF, 2'b00, 1));
        vecs.push_back(mk(0, 4'hF, 0, 16'h0000, 0, 0, 3'd0, 4'hF, 16'h0000, 8'h22, 2'b11, 1));
        vecs.push_back(mk(0, 4'hF, 0, 16'h0000, 0, 0, 3'd0, 4'hF, 16'h0000, 8'h55, 2'b00, 1));
        vecs.push_back(mk(0, 4'hF, 0, 16'h0000, 1, 1, 3'd0, 4'hF, 16'h0000, 8'h08, 2'b00, 1));
        vecs.push_back(mk(0, 4'hF, 0, 16'h0000, 0, 0, 3'd0, 4'hF, 16'h0000, 8'h3B, 2'b00, 1));
`else
        vecs.push_back(mk(0, 4'hF, 0, 16'h0000, 0, 0, 3'd0, 4'hF, 16'h0000, 8'hFF, 2'b11, 1));
        vecs.push_back(mk(0, 4'hF, 0, 16'h0000, 0, 0, 3'd0, 4'hF, 16'h0000, 8'hFF, 2'b11, 1));
        vecs.push_back(mk(0, 4'hF, 0, 16'h0000, 0, 0, 3'd0, 4'hF, 16'h0000, 8'hFF, 2'b11, 1));
        vecs.push_back(mk(0, 4'hF, 0, 16'h0000, 1, 1, 3'd0, 4'hF, 16'h0000, 8'h0F, 2'b01, 1));
        vecs.push_back(mk(0, 4'hF, 0, 16'h0000, 0, 0, 3'd0, 4'hF, 16'h0000, 8'h3F, 2'b01, 1));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            rst          = vecs[i].rst;
            bus.sig      = vecs[i].sig;
            bus.flip     = vecs[i].flip;
            bus.pass_in  = vecs[i].pass_in;
            bus.cfg_we   = vecs[i].cfg_we;
            bus.cfg_ch   = vecs[i].cfg_ch;
            bus.cfg_mode = vecs[i].cfg_mode;
            @(posedge clk);
            #1;
            check($sformatf("v%0d sig_out", i),   32'(bus.sig_out),   32'(vecs[i].e_sig));
            check($sformatf("v%0d pass_out", i),  32'(bus.pass_out),  32'(vecs[i].e_pass));
            check($sformatf("v%0d acc_out", i),   32'(bus.acc_out),   32'(vecs[i].e_acc));
            check($sformatf("v%0d acc_sat", i),   32'(bus.acc_sat),   32'(vecs[i].e_sat));
            check($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_valid));
        end

        // Lane-0 mode walk: PASS, HOLD, ZERO, COUNT, reserved(5); each write clears acc0
        // and the old mode still governs the sample taken on the write edge.
        hstep(0,  2'd0, 1'b1, 3'd0, 2'd3, 4'd0);
        hstep(1,  2'd1, 1'b0, 3'd0, 2'd0, 4'd1);
        hstep(2,  2'd2, 1'b0, 3'd0, 2'd1, 4'd3);
        hstep(3,  2'd3, 1'b1, 3'd1, 2'd2, 4'd0);
        hstep(4,  2'd0, 1'b0, 3'd0, 2'd3, 4'd0);
        hstep(5,  2'd1, 1'b0, 3'd0, 2'd3, 4'd0);
        hstep(6,  2'd2, 1'b0, 3'd0, 2'd3, 4'd0);
        hstep(7,  2'd3, 1'b1, 3'd2, 2'd3, 4'd0);
        hstep(8,  2'd1, 1'b0, 3'd0, 2'd3, 4'd1);
        hstep(9,  2'd2, 1'b0, 3'd0, 2'd0, 4'd3);
        hstep(10, 2'd3, 1'b1, 3'd3, 2'd0, 4'd0);
        hstep(11, 2'd1, 1'b0, 3'd0, 2'd0, 4'd1);
        hstep(12, 2'd2, 1'b0, 3'd0, 2'd0, 4'd3);
        hstep(13, 2'd1, 1'b0, 3'd0, 2'd1, 4'd4);
        hstep(14, 2'd0, 1'b1, 3'd5, 2'd3, 4'd0);
        hstep(15, 2'd2, 1'b0, 3'd0, 2'd0, 4'd2);
        hstep(16, 2'd0, 1'b0, 3'd0, 2'd2, 4'd2);
        hstep(17, 2'd0, 1'b0, 3'd0, 2'd0, 4'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
